// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Latency: none, package only.
// Backpressure: none, package only.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        BR_FLUSH = 2'd2
    } hcu_state_t;

    localparam int LOAD_USE_DELAY_MIN     = 1;
    localparam int LOAD_USE_DELAY_MAX     = 3;
    localparam int BRANCH_FLUSH_DEPTH_MIN = 1;
    localparam int BRANCH_FLUSH_DEPTH_MAX = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count reflects inc/clr one clock after they are sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk, rst_n (async active-low), inc, clr (wins over inc), count.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use stall, late-branch flush and memory-busy freeze control for a 5-stage pipe.
// Latency: control outputs are combinational from state + inputs; counters lag one clock.
// Backpressure: mem_busy freezes the whole pipe and holds the FSM; it outranks branch and hazard.
// Ports: ID/EX register specifiers and load/branch/busy flags in; PC, IF/ID, ID/EX and
//        EX/MEM enables/flush/bubble out; saturating stall_cnt and flush_cnt out.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W         = 5,
    parameter int LOAD_USE_DELAY     = 1,
    parameter int BRANCH_FLUSH_DEPTH = 1,
    parameter int CNT_W              = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_busy,
    input  logic                  clr_cnt,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_bubble,
    output logic                  if_id_flush,
    output logic                  ex_mem_hold,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    if (LOAD_USE_DELAY < LOAD_USE_DELAY_MIN || LOAD_USE_DELAY > LOAD_USE_DELAY_MAX) begin : g_bad_lud
        $error("hazard_control_unit: LOAD_USE_DELAY must be 1..3");
    end
    if (BRANCH_FLUSH_DEPTH < BRANCH_FLUSH_DEPTH_MIN ||
        BRANCH_FLUSH_DEPTH > BRANCH_FLUSH_DEPTH_MAX) begin : g_bad_bfd
        $error("hazard_control_unit: BRANCH_FLUSH_DEPTH must be 1..2");
    end

    hcu_state_t state_q, state_d;
    logic [1:0] rem_q, rem_d;
    logic       hazard;

    // Register 0 is hardwired zero, so a load targeting it can never feed a consumer.
    assign hazard = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        ex_mem_hold  = 1'b0;

        if (mem_busy) begin
            // Whole pipe frozen; FSM and countdown hold.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_mem_hold = 1'b1;
        end else if (ex_branch_taken) begin
            // Taken branch from any state: kill wrong path, abandon any pending stall.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = (BRANCH_FLUSH_DEPTH == 2) ? BR_FLUSH : RUN;
            rem_d        = 2'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hazard) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        if (LOAD_USE_DELAY > 1) begin
                            state_d = LD_STALL;
                            rem_d   = 2'(LOAD_USE_DELAY - 1);
                        end
                    end
                end
                LD_STALL: begin
                    // Countdown only; the hazard is not re-checked until back in RUN.
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (rem_q == 2'd1) begin
                        state_d = RUN;
                        rem_d   = 2'd0;
                    end else begin
                        rem_d = rem_q - 2'd1;
                    end
                end
                BR_FLUSH: begin
                    if_id_flush = 1'b1;
                    state_d     = RUN;
                end
                default: begin
                    state_d = RUN;
                    rem_d   = 2'd0;
                end
            endcase
        end

        // While reset is asserted the pipe is held with a NOP in ID/EX.
        if (!rst_n) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b0;
            ex_mem_hold  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            rem_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!pc_write),
        .clr   (clr_cnt),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (if_id_flush),
        .clr   (clr_cnt),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: two instances (delay 1/depth 1/4-bit counters and
// delay 3/depth 2/16-bit counters) share one stimulus stream; a behavioural model
// pushes expected outputs per cycle and they are popped and compared mid-cycle.
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rt, ex_mem_read, ex_branch_taken, mem_busy, clr_cnt;

    logic        a_pc, a_ifw, a_bub, a_fl, a_hold;
    logic [3:0]  a_scnt, a_fcnt;
    logic        b_pc, b_ifw, b_bub, b_fl, b_hold;
    logic [15:0] b_scnt, b_fcnt;

    always #5 clk = ~clk;

    hazard_control_unit #(.REG_ADDR_W(5), .LOAD_USE_DELAY(1), .BRANCH_FLUSH_DEPTH(1), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .clr_cnt(clr_cnt), .pc_write(a_pc), .if_id_write(a_ifw),
        .id_ex_bubble(a_bub), .if_id_flush(a_fl), .ex_mem_hold(a_hold),
        .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
    );

    hazard_control_unit #(.REG_ADDR_W(5), .LOAD_USE_DELAY(3), .BRANCH_FLUSH_DEPTH(2), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .clr_cnt(clr_cnt), .pc_write(b_pc), .if_id_write(b_ifw),
        .id_ex_bubble(b_bub), .if_id_flush(b_fl), .ex_mem_hold(b_hold),
        .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
    );

    // Control vector order: {pc_write, if_id_write, id_ex_bubble, if_id_flush, ex_mem_hold}
    localparam logic [4:0] O_IDLE   = 5'b11000;
    localparam logic [4:0] O_STALL  = 5'b00100;
    localparam logic [4:0] O_FREEZE = 5'b00001;
    localparam logic [4:0] O_BRANCH = 5'b11110;
    localparam logic [4:0] O_FLUSH2 = 5'b11010;
    localparam logic [4:0] O_RESET  = 5'b00100;

    typedef struct packed {
        logic [4:0]  o;
        logic [15:0] s;
        logic [15:0] f;
    } exp_t;

    exp_t sb_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    int lud[2] = '{1, 3};
    int bfd[2] = '{1, 2};
    int cw[2]  = '{4, 16};
    int stall_left[2];
    bit flush_pend[2];
    int scnt[2];
    int fcnt[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    endtask

    task automatic model_step(input int i, output exp_t e);
        logic [4:0] o;
        logic       hz;
        int         mx;
        mx = (1 << cw[i]) - 1;
        hz = ex_mem_read && (ex_rd != 0) && ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
        if (!rst_n) begin
            stall_left[i] = 0;
            flush_pend[i] = 0;
            scnt[i] = 0;
            fcnt[i] = 0;
            e.o = O_RESET;
            e.s = 16'd0;
            e.f = 16'd0;
        end else begin
            if (mem_busy) begin
                o = O_FREEZE;
            end else if (ex_branch_taken) begin
                o = O_BRANCH;
                stall_left[i] = 0;
                flush_pend[i] = (bfd[i] == 2);
            end else if (flush_pend[i]) begin
                o = O_FLUSH2;
                flush_pend[i] = 0;
            end else if (stall_left[i] > 0) begin
                o = O_STALL;
                stall_left[i]--;
            end else if (hz) begin
                o = O_STALL;
                stall_left[i] = lud[i] - 1;
            end else begin
                o = O_IDLE;
            end
            e.o = o;
            e.s = 16'(scnt[i]);
            e.f = 16'(fcnt[i]);
            if (clr_cnt) begin
                scnt[i] = 0;
                fcnt[i] = 0;
            end else begin
                if (!o[4] && scnt[i] < mx) scnt[i]++;
                if (o[1] && fcnt[i] < mx) fcnt[i]++;
            end
        end
    endtask

    // One clock: predict, compare mid-cycle, then advance just past the next rising edge.
    task automatic tick();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            model_step(i, e);
            sb_q.push_back(e);
        end
        @(negedge clk);
        e = sb_q.pop_front();
        chk("a_ctl",   {27'd0, a_pc, a_ifw, a_bub, a_fl, a_hold}, {27'd0, e.o});
        chk("a_stall", {28'd0, a_scnt}, {16'd0, e.s});
        chk("a_flush", {28'd0, a_fcnt}, {16'd0, e.f});
        e = sb_q.pop_front();
        chk("b_ctl",   {27'd0, b_pc, b_ifw, b_bub, b_fl, b_hold}, {27'd0, e.o});
        chk("b_stall", {16'd0, b_scnt}, {16'd0, e.s});
        chk("b_flush", {16'd0, b_fcnt}, {16'd0, e.f});
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        id_rs = 5'd1; id_rt = 5'd2; ex_rd = 5'd3; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic clear_counters();
        idle_in();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_in();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic load-use on rs
        clear_counters();
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
        tick();
        idle_in();
        repeat (4) tick();
        chk("t1_a_stall_cnt", 32'(a_scnt), 32'd1);
        chk("t1_b_stall_cnt", 32'(b_scnt), 32'd3);

        // rt source, consumed and not consumed
        clear_counters();
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
        tick();
        idle_in();
        repeat (3) tick();
        chk("t2_b_stall_cnt", 32'(b_scnt), 32'd3);
        clear_counters();
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b0;
        tick();
        idle_in();
        tick();
        chk("t2_nouse_stall_cnt", 32'(b_scnt), 32'd0);

        // Register 0 never hazards
        clear_counters();
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
        repeat (2) tick();
        chk("t3_r0_stall_cnt", 32'(b_scnt), 32'd0);

        // Branch arriving in the 2nd stall cycle
        clear_counters();
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
        tick();
        idle_in();
        ex_branch_taken = 1'b1;
        tick();
        idle_in();
        repeat (3) tick();
        chk("t4_a_flush_cnt", 32'(a_fcnt), 32'd1);
        chk("t4_b_flush_cnt", 32'(b_fcnt), 32'd2);
        chk("t4_b_stall_cnt", 32'(b_scnt), 32'd1);

        // mem_busy for 4 cycles in the middle of a stall
        clear_counters();
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
        tick();
        idle_in();
        tick();
        mem_busy = 1'b1;
        repeat (4) tick();
        mem_busy = 1'b0;
        repeat (3) tick();
        chk("t5_a_stall_cnt", 32'(a_scnt), 32'd5);
        chk("t5_b_stall_cnt", 32'(b_scnt), 32'd7);

        // Counter saturation and clear racing a hazard
        clear_counters();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        repeat (20) tick();
        chk("t6_a_sat", 32'(a_scnt), 32'd15);
        chk("t6_b_cnt", 32'(b_scnt), 32'd20);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("t6_a_clr", 32'(a_scnt), 32'd0);
        chk("t6_b_clr", 32'(b_scnt), 32'd0);

        // Reset mid-stall: outputs forced at once, pipe resumes in RUN
        idle_in();
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
        tick();
        idle_in();
        rst_n = 1'b0;
        #1;
        chk("t7_b_rst_ctl", {27'd0, b_pc, b_ifw, b_bub, b_fl, b_hold}, {27'd0, O_RESET});
        chk("t7_b_rst_cnt", 32'(b_scnt), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Random traffic through the scoreboard
        for (int n = 0; n < 400; n++) begin
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            id_uses_rt      = 1'($urandom_range(0, 1));
            ex_mem_read     = ($urandom_range(0, 2) != 0);
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            mem_busy        = ($urandom_range(0, 9) == 0);
            clr_cnt         = ($urandom_range(0, 49) == 0);
            rst_n           = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_n = 1'b1;
        idle_in();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
